wb_dma_master: RTL and testbench

//  Wishbone initiator that copies LEN 32-bit words from SRC to DST address.
//  It reads a chunk of up to BUF_DEPTH words into a local buffer, then writes

---
 rtl/wb_dma_master_pkg.sv | 19 +
 rtl/wb_dma_master_buf.sv | 54 +++++
 rtl/wb_dma_master.sv | 186 ++++++++++++++++++
 tb/tb_wb_dma_master.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_dma_master_pkg.sv
// Shared types and constants for the Wishbone DMA copy engine.
package wb_dma_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
        ST_FIN   = 3'd3,
        ST_ABORT = 3'd4
    } dma_state_t;

    localparam logic [3:0]  WB_SEL_ALL = 4'hf;
    localparam logic [31:0] ADR_STEP   = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] adr);
        return adr & ~32'h3;
    endfunction

endpackage

// File: rtl/wb_dma_master_buf.sv
// Register FIFO holding one read chunk until it is written back out.
module wb_dma_master_buf #(
    parameter int DEPTH = 4
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rstn_i,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [31:0]               din,
    output logic [31:0]               dout,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push & (count != CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_dma_master.sv
// Wishbone initiator copying len_i words from src to dst, one buffered chunk at a time.
//  state | meaning
//  IDLE  | waiting for start_i
//  RD    | reading a chunk into the buffer (cyc low for one cycle on entry from WR)
//  WR    | writing the buffered chunk out
//  FIN   | pulse done_o, drop busy_o
//  ABORT | ack timeout seen, flush buffer
module wb_dma_master
    import wb_dma_master_pkg::*;
#(
    parameter int LEN_W     = 11,
    parameter int BUF_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rstn_i,
    input  logic             start_i,
    input  logic [31:0]      src_adr_i,
    input  logic [31:0]      dst_adr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    dma_state_t       state;
    logic [31:0]      src_adr;
    logic [31:0]      dst_adr;
    logic [LEN_W-1:0] remaining;
    logic [7:0]       to_cnt;

    logic             ack_hit;
    logic             timed_out;
    logic             rd_last;
    logic             buf_push;
    logic             buf_pop;
    logic             buf_flush;
    logic             buf_empty;
    logic [31:0]      buf_dout;
    logic [CW-1:0]    buf_count;

    // Acks are only meaningful while stb is up; anything else is stale.
    assign ack_hit   = wbm_stb_o & wbm_ack_i;
    assign timed_out = wbm_stb_o & ~wbm_ack_i & (to_cnt == 8'(TIMEOUT));
    assign buf_push  = (state == ST_RD) & ack_hit;
    assign buf_pop   = (state == ST_WR) & ack_hit & ~buf_empty;
    assign buf_flush = (state == ST_ABORT);

    // Remaining only shrinks in WR, so during RD it bounds the chunk directly.
    assign rd_last = (buf_count == CW'(BUF_DEPTH - 1)) ||
                     ((LEN_W'(buf_count) + LEN_W'(1)) == remaining);

    wb_dma_master_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .wb_clk_i  (wb_clk_i),
        .wb_rstn_i (wb_rstn_i),
        .push      (buf_push),
        .pop       (buf_pop),
        .flush     (buf_flush),
        .din       (wbm_dat_i),
        .dout      (buf_dout),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state     <= ST_IDLE;
            src_adr   <= '0;
            dst_adr   <= '0;
            remaining <= '0;
            to_cnt    <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            if ((state == ST_RD || state == ST_WR) && timed_out) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                wbm_we_o  <= 1'b0;
                wbm_sel_o <= '0;
                wbm_adr_o <= '0;
                wbm_dat_o <= '0;
                err_o     <= 1'b1;
                busy_o    <= 1'b0;
                to_cnt    <= '0;
                state     <= ST_ABORT;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_i) begin
                            if (len_i == '0) begin
                                done_o <= 1'b1;
                            end else begin
                                src_adr   <= word_align(src_adr_i);
                                dst_adr   <= word_align(dst_adr_i);
                                remaining <= len_i;
                                busy_o    <= 1'b1;
                                wbm_cyc_o <= 1'b1;
                                wbm_stb_o <= 1'b1;
                                wbm_we_o  <= 1'b0;
                                wbm_sel_o <= WB_SEL_ALL;
                                wbm_adr_o <= word_align(src_adr_i);
                                to_cnt    <= '0;
                                state     <= ST_RD;
                            end
                        end
                    end
                    ST_RD: begin
                        if (ack_hit) begin
                            src_adr   <= src_adr + ADR_STEP;
                            wbm_stb_o <= 1'b0;
                            wbm_sel_o <= '0;
                            to_cnt    <= '0;
                            if (rd_last) begin
                                wbm_cyc_o <= 1'b0;
                                state     <= ST_WR;
                            end
                        end else if (wbm_stb_o) begin
                            to_cnt <= to_cnt + 8'd1;
                        end else begin
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_we_o  <= 1'b0;
                            wbm_sel_o <= WB_SEL_ALL;
                            wbm_adr_o <= src_adr;
                            to_cnt    <= '0;
                        end
                    end
                    ST_WR: begin
                        if (ack_hit) begin
                            dst_adr   <= dst_adr + ADR_STEP;
                            remaining <= remaining - LEN_W'(1);
                            wbm_stb_o <= 1'b0;
                            wbm_sel_o <= '0;
                            wbm_dat_o <= '0;
                            to_cnt    <= '0;
                            if (buf_count == CW'(1)) begin
                                wbm_cyc_o <= 1'b0;
                                wbm_we_o  <= 1'b0;
                                state     <= (remaining == LEN_W'(1)) ? ST_FIN : ST_RD;
                            end
                        end else if (wbm_stb_o) begin
                            to_cnt <= to_cnt + 8'd1;
                        end else begin
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_we_o  <= 1'b1;
                            wbm_sel_o <= WB_SEL_ALL;
                            wbm_adr_o <= dst_adr;
                            wbm_dat_o <= buf_dout;
                            to_cnt    <= '0;
                        end
                    end
                    ST_FIN: begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end
                    ST_ABORT: begin
                        remaining <= '0;
                        state     <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_dma_master.sv
// Scoreboard bench for wb_dma_master against a single-cycle-ack blockram port model.
`timescale 1ns/1ps
module tb_wb_dma_master;
    localparam int LEN_W = 11;

    logic             wb_clk_i = 1'b0;
    logic             wb_rstn_i = 1'b0;
    logic             start_i = 1'b0;
    logic [31:0]      src_adr_i = '0;
    logic [31:0]      dst_adr_i = '0;
    logic [LEN_W-1:0] len_i = '0;
    logic             busy_o, done_o, err_o;
    logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]       wbm_sel_o;
    logic [31:0]      wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic             wbm_ack_i;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_dma_master #(.LEN_W(LEN_W), .BUF_DEPTH(4), .TIMEOUT(255)) dut (
        .wb_clk_i(wb_clk_i), .wb_rstn_i(wb_rstn_i), .start_i(start_i),
        .src_adr_i(src_adr_i), .dst_adr_i(dst_adr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] salt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int idx);
        if (idx < 8) return 32'(idx);
        return (32'(idx) * 32'h9E37_79B9) ^ salt;
    endfunction

    // Blockram port model: ack one cycle after stb, held one cycle.
    logic [31:0] ram [2048];
    bit          ram_valid [2048];
    logic        ack_r;
    logic        stray_ack = 1'b0;
    int          slave_reads = 0;
    int          ack_limit = 32'h7fff_ffff;
    assign wbm_ack_i = ack_r | stray_ack;

    always @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            ack_r     <= 1'b0;
            wbm_dat_i <= '0;
        end else begin
            ack_r <= 1'b0;
            if (wbm_cyc_o && wbm_stb_o && !ack_r && (wbm_we_o || slave_reads < ack_limit)) begin
                ack_r <= 1'b1;
                if (wbm_we_o) begin
                    ram[wbm_adr_o[12:2]]       <= wbm_dat_o;
                    ram_valid[wbm_adr_o[12:2]] <= 1'b1;
                end else begin
                    wbm_dat_i   <= ram_valid[wbm_adr_o[12:2]] ? ram[wbm_adr_o[12:2]]
                                                              : init_word(int'(wbm_adr_o[12:2]));
                    slave_reads <= slave_reads + 1;
                end
            end
        end
    end

    // Reference model: memory contents as a copy engine should leave them.
    logic [31:0] mdl_val [2048];
    bit          mdl_set [2048];
    function automatic logic [31:0] model_rd(input logic [31:0] adr);
        return mdl_set[adr[12:2]] ? mdl_val[adr[12:2]] : init_word(int'(adr[12:2]));
    endfunction

    logic [31:0] exp_rd [$];
    logic [63:0] exp_wr [$];
    logic [1:0]  exp_evt [$];
    int          rd_chunks [$];
    int rd_beats = 0, wr_beats = 0, evt_seen = 0;
    int stall = 0, last_stall = 0, sess_beats = 0;
    bit prev_cyc = 0, sess_we = 0;

    always @(negedge wb_clk_i) begin
        logic [63:0] e;
        if (!wb_rstn_i) begin
            prev_cyc = 0;
            stall    = 0;
        end else begin
            if (wbm_stb_o) begin
                chk("cyc_with_stb", 64'(wbm_cyc_o), 64'd1);
                chk("sel_active", 64'(wbm_sel_o), 64'hf);
                chk("adr_align", 64'(wbm_adr_o[1:0]), 64'd0);
            end else begin
                chk("sel_idle", 64'(wbm_sel_o), 64'd0);
            end
            if (wbm_cyc_o && !prev_cyc) sess_beats = 0;
            if (wbm_cyc_o) sess_we = wbm_we_o;
            if (!wbm_cyc_o && prev_cyc && !sess_we) rd_chunks.push_back(sess_beats);
            prev_cyc = wbm_cyc_o;

            if (wbm_stb_o && !wbm_ack_i) stall++;
            else if (wbm_stb_o) stall = 0;
            else begin
                if (stall > 0) last_stall = stall;
                stall = 0;
            end

            if (wbm_stb_o && wbm_ack_i) begin
                sess_beats++;
                if (wbm_we_o) begin
                    wr_beats++;
                    if (exp_wr.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_write: adr 0x%0h dat 0x%0h, none pending", wbm_adr_o, wbm_dat_o);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("wr_adr", 64'(wbm_adr_o), 64'(e[63:32]));
                        chk("wr_dat", 64'(wbm_dat_o), 64'(e[31:0]));
                        mdl_val[e[44:34]] = e[31:0];
                        mdl_set[e[44:34]] = 1'b1;
                    end
                end else begin
                    rd_beats++;
                    if (exp_rd.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_read: adr 0x%0h, none pending", wbm_adr_o);
                    end else begin
                        chk("rd_adr", 64'(wbm_adr_o), 64'(exp_rd.pop_front()));
                    end
                end
            end

            if (done_o || err_o) begin
                evt_seen++;
                if (exp_evt.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_event: done %0b err %0b, none pending", done_o, err_o);
                end else begin
                    chk("event_kind", 64'({err_o, done_o}), 64'(exp_evt.pop_front()));
                end
            end
        end
    end

    task automatic issue(input logic [31:0] s, input logic [31:0] d, input int n,
                         input int n_rd, input bit expect_err);
        for (int i = 0; i < n_rd; i++)
            exp_rd.push_back((s & ~32'h3) + 32'(4 * i));
        if (!expect_err)
            for (int i = 0; i < n; i++)
                exp_wr.push_back({(d & ~32'h3) + 32'(4 * i), model_rd((s & ~32'h3) + 32'(4 * i))});
        exp_evt.push_back(expect_err ? 2'b10 : 2'b01);
        @(negedge wb_clk_i);
        src_adr_i = s; dst_adr_i = d; len_i = LEN_W'(n); start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
    endtask

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int n_rd, input bit expect_err);
        int e0 = evt_seen, r0 = rd_beats, w0 = wr_beats, c0 = rd_chunks.size();
        int budget = 40 * n + 600, waited = 0, rem, k;
        issue(s, d, n, n_rd, expect_err);
        while (evt_seen == e0 && waited < budget) begin
            @(negedge wb_clk_i);
            waited++;
        end
        if (evt_seen == e0) begin
            n_checks++; n_fail++;
            $display("FAIL completion_timeout: no done/err after %0d cycles, len %0d", waited, n);
        end
        repeat (3) @(negedge wb_clk_i);
        chk("event_count", 64'(evt_seen - e0), 64'd1);
        chk("read_beats", 64'(rd_beats - r0), 64'(n_rd));
        chk("write_beats", 64'(wr_beats - w0), expect_err ? 64'd0 : 64'(n));
        chk("rd_drained", 64'(exp_rd.size()), 64'd0);
        chk("wr_drained", 64'(exp_wr.size()), 64'd0);
        chk("busy_after", 64'(busy_o), 64'd0);
        chk("cyc_after", 64'(wbm_cyc_o), 64'd0);
        if (!expect_err) begin
            rem = n; k = 0;
            while (rem > 0) begin
                if (c0 + k < rd_chunks.size())
                    chk("rd_chunk_size", 64'(rd_chunks[c0 + k]), 64'(rem > 4 ? 4 : rem));
                rem -= (rem > 4) ? 4 : rem;
                k++;
            end
            chk("rd_chunk_count", 64'(rd_chunks.size() - c0), 64'(k));
        end
        exp_rd.delete();
        exp_wr.delete();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_cyc"}, 64'(wbm_cyc_o), 64'd0);
        chk({tag, "_stb"}, 64'(wbm_stb_o), 64'd0);
        chk({tag, "_we"}, 64'(wbm_we_o), 64'd0);
        chk({tag, "_sel"}, 64'(wbm_sel_o), 64'd0);
        chk({tag, "_adr"}, 64'(wbm_adr_o), 64'd0);
        chk({tag, "_dat"}, 64'(wbm_dat_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_err"}, 64'(err_o), 64'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, w0, k, quiet;
        salt = $urandom;
        repeat (3) @(negedge wb_clk_i);
        chk_outputs_zero("reset");
        wb_rstn_i = 1'b1;

        // Two full chunks
        run_copy(32'h0, 32'h100, 8, 8, 0);
        for (int i = 0; i < 8; i++) chk("s1_dst_word", 64'(ram[32'h40 + i]), 64'(i));

        // Partial last chunk
        run_copy(32'h40, 32'h300, 5, 5, 0);

        // Zero length
        @(negedge wb_clk_i);
        e0 = evt_seen;
        exp_evt.push_back(2'b01);
        len_i = '0; src_adr_i = 32'h10; dst_adr_i = 32'h20; start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        chk("len0_done_next_cycle", 64'(done_o), 64'd1);
        quiet = (busy_o || wbm_cyc_o) ? 1 : 0;
        repeat (10) begin
            @(negedge wb_clk_i);
            if (busy_o || wbm_cyc_o) quiet++;
        end
        chk("len0_no_activity", 64'(quiet), 64'd0);
        chk("len0_event_count", 64'(evt_seen - e0), 64'd1);

        // Slave stalls after two reads
        ack_limit = slave_reads + 2;
        run_copy(32'h60, 32'h500, 6, 2, 1);
        ack_limit = 32'h7fff_ffff;
        chk("timeout_stall_window", 64'(last_stall >= 255 && last_stall <= 257), 64'd1);
        run_copy(32'h60, 32'h500, 6, 6, 0);

        // Start while busy and stray acks must be ignored
        fork
            run_copy(32'h0, 32'h200, 8, 8, 0);
            begin
                repeat (4) @(negedge wb_clk_i);
                src_adr_i = 32'h400; dst_adr_i = 32'h600; len_i = LEN_W'(3); start_i = 1'b1;
                @(negedge wb_clk_i);
                start_i = 1'b0;
                for (int j = 0; j < 2; j++) begin
                    k = 0;
                    do begin
                        @(negedge wb_clk_i);
                        k++;
                    end while (!(wbm_cyc_o && !wbm_stb_o) && k < 100);
                    if (k >= 100) begin
                        n_checks++; n_fail++;
                        $display("FAIL stray_ack_window: no stb gap within %0d cycles", k);
                    end
                    #1 stray_ack = 1'b1;
                    @(posedge wb_clk_i);
                    #1 stray_ack = 1'b0;
                end
            end
        join
        for (int i = 0; i < 8; i++) chk("s5_dst_word", 64'(ram[32'h80 + i]), 64'(i));

        // Reset during the write phase
        e0 = evt_seen;
        w0 = wr_beats;
        issue(32'h20, 32'h700, 8, 8, 0);
        k = 0;
        while (!((wr_beats - w0) >= 2 && wbm_stb_o && wbm_we_o && !wbm_ack_i) && k < 400) begin
            @(negedge wb_clk_i);
            k++;
        end
        if (k >= 400) begin
            n_checks++; n_fail++;
            $display("FAIL reset_window: write phase not reached in %0d cycles", k);
        end
        wb_rstn_i = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        chk("midreset_partial_writes", 64'(wr_beats - w0), 64'd2);
        repeat (4) @(negedge wb_clk_i);
        chk("midreset_no_event", 64'(evt_seen - e0), 64'd0);
        exp_rd.delete();
        exp_wr.delete();
        exp_evt.delete();
        wb_rstn_i = 1'b1;
        run_copy(32'h10, 32'h800, 1, 1, 0);

        // Address wrap at the top of the 32-bit space
        run_copy(32'hFFFF_FFF8, 32'h1F00, 4, 4, 0);

        // Randomized copies, with junk in the ignored address bits
        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(1, 20);
            logic [31:0] s = 32'h400 + 32'(4 * $urandom_range(0, 400)) + 32'($urandom_range(0, 3));
            logic [31:0] d = 32'h1000 + 32'(4 * $urandom_range(0, 900)) + 32'($urandom_range(0, 3));
            run_copy(s, d, n, n, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
